// File: rtl/aes_puf_session_ctrl_pkg.sv
// Shared types for the PUF-keyed AES session sequencer: FSM encoding, error codes, timer sizing.
package aes_puf_session_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_KEYGEN = 3'd1,
        ST_LOCK   = 3'd2,
        ST_LOAD   = 3'd3,
        ST_RUN    = 3'd4,
        ST_OUT    = 3'd5,
        ST_ERROR  = 3'd6
    } state_e;

    localparam logic [1:0] ERR_NONE    = 2'b00;
    localparam logic [1:0] ERR_KEY_TMO = 2'b01;
    localparam logic [1:0] ERR_AES_TMO = 2'b10;

    // One timer serves both waits, so it is sized for the longer timeout.
    function automatic int unsigned tmr_width(input int unsigned a, input int unsigned b);
        return $clog2((a > b) ? a : b) + 1;
    endfunction

endpackage

// File: rtl/aes_puf_session_ctrl_if.sv
// Bundles the session control, plaintext/ciphertext streams, key generator and AES core signals.
interface aes_puf_session_ctrl_if #(
    parameter int unsigned DATA_W = 128,
    parameter int unsigned CNT_W  = 16
);
    logic              start;
    logic              rekey;
    logic              clear_err;

    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              in_last;

    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic              out_last;

    logic              kg_reset;
    logic [DATA_W-1:0] kg_key;
    logic              kg_enable;

    logic              aes_reset;
    logic [DATA_W-1:0] aes_key;
    logic [DATA_W-1:0] aes_din;
    logic [DATA_W-1:0] aes_dout;
    logic              aes_done;

    logic              busy;
    logic              key_ready;
    logic              error;
    logic [1:0]        err_code;
    logic [CNT_W-1:0]  blk_count;

    modport slave (
        input  start, rekey, clear_err,
        input  in_valid, in_data, in_last,
        output in_ready,
        output out_valid, out_data, out_last,
        input  out_ready,
        output kg_reset,
        input  kg_key, kg_enable,
        output aes_reset, aes_key, aes_din,
        input  aes_dout, aes_done,
        output busy, key_ready, error, err_code, blk_count
    );

    modport master (
        output start, rekey, clear_err,
        output in_valid, in_data, in_last,
        input  in_ready,
        input  out_valid, out_data, out_last,
        output out_ready,
        input  kg_reset,
        output kg_key, kg_enable,
        input  aes_reset, aes_key, aes_din,
        output aes_dout, aes_done,
        input  busy, key_ready, error, err_code, blk_count
    );

endinterface

// File: rtl/aes_puf_session_ctrl_blk.sv
// Plaintext block FIFO: {last, data} entries, synchronous flush, popped and flushed slots are zeroized.
module aes_blk_fifo #(
    parameter  int unsigned WIDTH = 129,
    parameter  int unsigned DEPTH = 4,
    localparam int unsigned PTR_W = $clog2(DEPTH),
    localparam int unsigned CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             push_ok;
    logic             pop_ok;

    assign full    = (cnt_q == CNT_W'(DEPTH));
    assign empty   = (cnt_q == '0);
    assign count   = cnt_q;
    assign rdata   = mem_q[rd_ptr_q];
    assign push_ok = push & ~full;
    assign pop_ok  = pop & ~empty;

    // Push and pop never hit the same slot: that needs empty (no pop) or full (no push).
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (flush) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_d[i] = '0;
            end
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            cnt_d    = '0;
        end else begin
            if (push_ok) begin
                mem_d[wr_ptr_q] = wdata;
                wr_ptr_d        = wr_ptr_q + PTR_W'(1);
            end
            if (pop_ok) begin
                mem_d[rd_ptr_q] = '0;
                rd_ptr_d        = rd_ptr_q + PTR_W'(1);
            end
            cnt_d = cnt_q + CNT_W'(push_ok) - CNT_W'(pop_ok);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

endmodule

// File: rtl/aes_puf_session_ctrl.sv
// Session sequencer: obtains and locks a PUF key, then streams buffered plaintext blocks through the AES core.
module aes_puf_session_ctrl
    import aes_puf_session_ctrl_pkg::*;
#(
    parameter int unsigned DATA_W     = 128,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned KEY_TMO    = 4096,
    parameter int unsigned AES_TMO    = 64,
    parameter int unsigned KEEP_KEY   = 1,
    parameter int unsigned CNT_W      = 16
) (
    input logic                  clk,
    input logic                  reset,
    aes_puf_session_ctrl_if.slave bus
);

    localparam int unsigned TMR_W  = tmr_width(KEY_TMO, AES_TMO);
    localparam int unsigned FCNT_W = $clog2(FIFO_DEPTH) + 1;

    state_e            state_q, state_d;
    logic [TMR_W-1:0]  timer_q, timer_d;
    logic [DATA_W-1:0] key_q, key_d;
    logic              key_ready_q, key_ready_d;
    logic              last_r_q, last_r_d;
    logic [DATA_W-1:0] aes_din_q, aes_din_d;
    logic [DATA_W-1:0] out_data_q, out_data_d;
    logic              out_last_q, out_last_d;
    logic              out_valid_q, out_valid_d;
    logic              kg_reset_q, kg_reset_d;
    logic              aes_reset_q, aes_reset_d;
    logic              busy_q, busy_d;
    logic              error_q, error_d;
    logic [1:0]        err_code_q, err_code_d;
    logic [CNT_W-1:0]  blk_count_q, blk_count_d;
    logic              in_ready_q, in_ready_d;

    logic              fifo_push_c;
    logic              fifo_pop_c;
    logic              fifo_flush_c;
    logic [DATA_W:0]   fifo_rdata;
    logic              fifo_full;
    logic              fifo_empty;
    logic [FCNT_W-1:0] fifo_count;
    logic [FCNT_W-1:0] fifo_cnt_nxt_c;

    assign fifo_push_c  = bus.in_valid & in_ready_q & ~fifo_full;
    assign fifo_flush_c = (state_q == ST_ERROR);

    aes_blk_fifo #(
        .WIDTH (DATA_W + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .flush (fifo_flush_c),
        .push  (fifo_push_c),
        .wdata ({bus.in_last, bus.in_data}),
        .pop   (fifo_pop_c),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    // in_ready is registered, so it is derived from the occupancy the FIFO will have next cycle.
    assign fifo_cnt_nxt_c = fifo_flush_c ? '0
                          : fifo_count + FCNT_W'(fifo_push_c) - FCNT_W'(fifo_pop_c);

    always_comb begin
        state_d     = state_q;
        timer_d     = timer_q;
        key_d       = key_q;
        key_ready_d = key_ready_q;
        last_r_d    = last_r_q;
        aes_din_d   = aes_din_q;
        out_data_d  = out_data_q;
        out_last_d  = out_last_q;
        err_code_d  = err_code_q;
        blk_count_d = blk_count_q;
        fifo_pop_c  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    blk_count_d = '0;
                    err_code_d  = ERR_NONE;
                    timer_d     = '0;
                    state_d     = (bus.rekey || !key_ready_q) ? ST_KEYGEN : ST_LOAD;
                end
            end
            ST_KEYGEN: begin
                if (bus.kg_enable) begin
                    state_d = ST_LOCK;
                end else if (timer_q == TMR_W'(KEY_TMO - 1)) begin
                    state_d    = ST_ERROR;
                    err_code_d = ERR_KEY_TMO;
                end else begin
                    timer_d = timer_q + TMR_W'(1);
                end
            end
            ST_LOCK: begin
                key_d       = bus.kg_key;
                key_ready_d = 1'b1;
                state_d     = ST_LOAD;
            end
            ST_LOAD: begin
                if (!fifo_empty) begin
                    fifo_pop_c = 1'b1;
                    aes_din_d  = fifo_rdata[DATA_W-1:0];
                    last_r_d   = fifo_rdata[DATA_W];
                    timer_d    = '0;
                    state_d    = ST_RUN;
                end
            end
            ST_RUN: begin
                if (bus.aes_done) begin
                    out_data_d = bus.aes_dout;
                    out_last_d = last_r_q;
                    state_d    = ST_OUT;
                end else if (timer_q == TMR_W'(AES_TMO - 1)) begin
                    state_d    = ST_ERROR;
                    err_code_d = ERR_AES_TMO;
                end else begin
                    timer_d = timer_q + TMR_W'(1);
                end
            end
            ST_OUT: begin
                if (bus.out_ready) begin
                    blk_count_d = blk_count_q + CNT_W'(1);
                    out_data_d  = '0;
                    out_last_d  = 1'b0;
                    if (out_last_q) begin
                        state_d = ST_IDLE;
                        if (KEEP_KEY == 0) begin
                            key_d       = '0;
                            key_ready_d = 1'b0;
                        end
                    end else begin
                        state_d = ST_LOAD;
                    end
                end
            end
            ST_ERROR: begin
                if (bus.clear_err) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // A stale key is dropped as soon as a new one is requested or the session fails.
        if (state_d == ST_ERROR || (state_d == ST_KEYGEN && state_q != ST_KEYGEN)) begin
            key_d       = '0;
            key_ready_d = 1'b0;
        end
        if (state_d != ST_RUN) begin
            aes_din_d = '0;
        end

        kg_reset_d  = !(state_d == ST_KEYGEN || state_d == ST_LOCK);
        aes_reset_d = (state_d != ST_RUN);
        out_valid_d = (state_d == ST_OUT);
        busy_d      = !(state_d == ST_IDLE || state_d == ST_ERROR);
        error_d     = (state_d == ST_ERROR);
        in_ready_d  = (state_d != ST_ERROR) && (fifo_cnt_nxt_c != FCNT_W'(FIFO_DEPTH));
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            timer_q     <= '0;
            key_q       <= '0;
            key_ready_q <= 1'b0;
            last_r_q    <= 1'b0;
            aes_din_q   <= '0;
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
            out_valid_q <= 1'b0;
            kg_reset_q  <= 1'b1;
            aes_reset_q <= 1'b1;
            busy_q      <= 1'b0;
            error_q     <= 1'b0;
            err_code_q  <= ERR_NONE;
            blk_count_q <= '0;
            in_ready_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            timer_q     <= timer_d;
            key_q       <= key_d;
            key_ready_q <= key_ready_d;
            last_r_q    <= last_r_d;
            aes_din_q   <= aes_din_d;
            out_data_q  <= out_data_d;
            out_last_q  <= out_last_d;
            out_valid_q <= out_valid_d;
            kg_reset_q  <= kg_reset_d;
            aes_reset_q <= aes_reset_d;
            busy_q      <= busy_d;
            error_q     <= error_d;
            err_code_q  <= err_code_d;
            blk_count_q <= blk_count_d;
            in_ready_q  <= in_ready_d;
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_last  = out_last_q;
    assign bus.kg_reset  = kg_reset_q;
    assign bus.aes_reset = aes_reset_q;
    assign bus.aes_key   = key_q;
    assign bus.aes_din   = aes_din_q;
    assign bus.busy      = busy_q;
    assign bus.key_ready = key_ready_q;
    assign bus.error     = error_q;
    assign bus.err_code  = err_code_q;
    assign bus.blk_count = blk_count_q;

endmodule

// File: tb/tb_aes_puf_session_ctrl.sv
// Scoreboard bench for aes_puf_session_ctrl with key generator and AES core stubs.
module tb_aes_puf_session_ctrl;

    localparam int unsigned DW      = 128;
    localparam int unsigned CW      = 16;
    localparam int unsigned KEY_TMO = 4096;
    localparam int unsigned AES_TMO = 64;

    localparam logic [127:0] K1  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] PT1 = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] CT1 = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] K2  = 128'h000102030405060708090a0b0c0d0e0f;

    typedef struct packed {
        logic [127:0] data;
        logic         last;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    int   total = 0;
    int   bad   = 0;
    exp_t exp_q[$];

    logic [127:0] kg_val;
    bit           kg_block  = 1'b0;
    bit           aes_block = 1'b0;

    aes_puf_session_ctrl_if #(.DATA_W(DW), .CNT_W(CW)) bus ();

    aes_puf_session_ctrl #(
        .DATA_W     (DW),
        .FIFO_DEPTH (4),
        .KEY_TMO    (KEY_TMO),
        .AES_TMO    (AES_TMO),
        .KEEP_KEY   (1),
        .CNT_W      (CW)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Stand-in cipher: the real FIPS-197 vector is recognised, anything else gets a cheap keyed scramble.
    function automatic logic [127:0] fake_aes(input logic [127:0] d, input logic [127:0] k);
        if (d == PT1 && k == K1) return CT1;
        return d ^ {k[63:0], k[127:64]} ^ 128'h5a5a5a5a_a5a5a5a5_0f0f0f0f_f0f0f0f0;
    endfunction

    task automatic check_w(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic check_b(input string name, input logic act, input logic exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %b want %b", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [127:0] d, input logic last, input logic [127:0] exp_d, input bit has_exp);
        int n;
        n = 0;
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        bus.in_last  = last;
        while (!bus.in_ready && n < 100) begin
            tick();
            n++;
        end
        if (n >= 100) begin
            total++;
            bad++;
            $display("FAIL push_wait: in_ready still 0 after %0d cycles, want 1", n);
        end
        if (has_exp) exp_q.push_back('{data: exp_d, last: last});
        tick();
        bus.in_valid = 1'b0;
    endtask

    task automatic start_session(input logic rk);
        bus.start = 1'b1;
        bus.rekey = rk;
        tick();
        bus.start = 1'b0;
        bus.rekey = 1'b0;
    endtask

    task automatic wait_idle(output bit kg_low);
        int n;
        n      = 0;
        kg_low = 1'b0;
        while (bus.busy && n < 2000) begin
            if (!bus.kg_reset) kg_low = 1'b1;
            tick();
            n++;
        end
        check_b("wait_idle_busy", bus.busy, 1'b0);
    endtask

    task automatic wait_run();
        int n;
        n = 0;
        while (bus.aes_reset && n < 200) begin
            tick();
            n++;
        end
        check_b("wait_run_aes_reset", bus.aes_reset, 1'b0);
    endtask

    task automatic clear_error();
        bus.clear_err = 1'b1;
        tick();
        bus.clear_err = 1'b0;
    endtask

    // Key generator stub: key valid two cycles after its reset is released, unless blocked.
    initial begin
        int kc;
        kc            = 0;
        bus.kg_enable = 1'b0;
        bus.kg_key    = '0;
        forever begin
            @(negedge clk);
            if (reset || bus.kg_reset) begin
                kc            = 0;
                bus.kg_enable = 1'b0;
                bus.kg_key    = '0;
            end else begin
                if (!kg_block) kc++;
                if (kc >= 2) begin
                    bus.kg_enable = 1'b1;
                    bus.kg_key    = kg_val;
                end
            end
        end
    end

    // AES core stub: one-cycle done pulse three cycles after hold release, unless suppressed.
    initial begin
        int ac;
        ac           = 0;
        bus.aes_done = 1'b0;
        bus.aes_dout = '0;
        forever begin
            @(negedge clk);
            if (reset || bus.aes_reset) begin
                ac           = 0;
                bus.aes_done = 1'b0;
                bus.aes_dout = '0;
            end else begin
                ac++;
                if (ac == 3 && !aes_block) begin
                    bus.aes_done = 1'b1;
                    bus.aes_dout = fake_aes(bus.aes_din, bus.aes_key);
                end else begin
                    bus.aes_done = 1'b0;
                end
            end
        end
    end

    // Output monitor: every presented ciphertext must equal the head of the expected queue.
    initial begin
        forever begin
            @(negedge clk);
            if (!reset && bus.out_valid) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL out_unexpected: got %h want no output", bus.out_data);
                end else begin
                    check_w("out_data", bus.out_data, exp_q[0].data);
                    check_b("out_last", bus.out_last, exp_q[0].last);
                    if (bus.out_ready) void'(exp_q.pop_front());
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        bit kg_low;
        int n;
        reset         = 1'b1;
        kg_val        = K1;
        bus.start     = 1'b0;
        bus.rekey     = 1'b0;
        bus.clear_err = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.in_last   = 1'b0;
        bus.out_ready = 1'b1;
        repeat (3) tick();

        // Reset values
        check_b("rst_kg_reset", bus.kg_reset, 1'b1);
        check_b("rst_aes_reset", bus.aes_reset, 1'b1);
        check_b("rst_in_ready", bus.in_ready, 1'b0);
        check_b("rst_key_ready", bus.key_ready, 1'b0);
        check_b("rst_busy", bus.busy, 1'b0);
        check_b("rst_out_valid", bus.out_valid, 1'b0);
        check_w("rst_aes_key", bus.aes_key, 128'h0);
        reset = 1'b0;
        tick();
        check_b("post_rst_in_ready", bus.in_ready, 1'b1);

        // T1: single FIPS-197 block with a fresh PUF key
        push(PT1, 1'b1, CT1, 1'b1);
        start_session(1'b0);
        wait_idle(kg_low);
        check_b("t1_keygen_ran", kg_low, 1'b1);
        check_w("t1_blk_count", 128'(bus.blk_count), 128'(1));
        check_b("t1_key_ready", bus.key_ready, 1'b1);
        check_w("t1_aes_key", bus.aes_key, K1);
        check_w("t1_queue_left", 128'(exp_q.size()), 128'(0));

        // T2: four back-to-back blocks, downstream stalled; key reused without KEYGEN
        bus.out_ready = 1'b0;
        push(128'h00112233445566778899aabbccddeeff, 1'b0,
             fake_aes(128'h00112233445566778899aabbccddeeff, K1), 1'b1);
        check_b("t2_in_ready_1", bus.in_ready, 1'b1);
        push(128'h0f1e2d3c4b5a69788796a5b4c3d2e1f0, 1'b0,
             fake_aes(128'h0f1e2d3c4b5a69788796a5b4c3d2e1f0, K1), 1'b1);
        push(128'hdeadbeef_cafef00d_01234567_89abcdef, 1'b0,
             fake_aes(128'hdeadbeef_cafef00d_01234567_89abcdef, K1), 1'b1);
        check_b("t2_in_ready_3", bus.in_ready, 1'b1);
        push(128'hffffffff_00000000_ffffffff_00000000, 1'b1,
             fake_aes(128'hffffffff_00000000_ffffffff_00000000, K1), 1'b1);
        check_b("t2_in_ready_full", bus.in_ready, 1'b0);
        bus.in_valid = 1'b1;
        bus.in_data  = 128'h1111_2222_3333_4444_5555_6666_7777_8888;
        bus.in_last  = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        check_b("t2_in_ready_refused", bus.in_ready, 1'b0);
        start_session(1'b0);
        repeat (12) tick();
        check_b("t2_stalled_valid", bus.out_valid, 1'b1);
        check_b("t2_kg_reset_held", bus.kg_reset, 1'b1);
        bus.out_ready = 1'b1;
        wait_idle(kg_low);
        check_b("t2_no_keygen", kg_low, 1'b0);
        check_w("t2_blk_count", 128'(bus.blk_count), 128'(4));
        check_w("t2_queue_left", 128'(exp_q.size()), 128'(0));

        // T5: rekey forces KEYGEN and the new key is used
        kg_val = K2;
        push(128'hcafebabe_00000001_00000002_00000003, 1'b1,
             fake_aes(128'hcafebabe_00000001_00000002_00000003, K2), 1'b1);
        start_session(1'b1);
        wait_idle(kg_low);
        check_b("t5_rekey_keygen", kg_low, 1'b1);
        check_w("t5_aes_key", bus.aes_key, K2);
        check_w("t5_blk_count", 128'(bus.blk_count), 128'(1));

        // T3: key generator never answers
        kg_block = 1'b1;
        start_session(1'b1);
        n = 0;
        while (!bus.error && n < int'(KEY_TMO) + 50) begin
            tick();
            n++;
        end
        check_w("t3_tmo_cycles", 128'(n), 128'(KEY_TMO));
        check_w("t3_err_code", 128'(bus.err_code), 128'(2'b01));
        check_b("t3_key_ready", bus.key_ready, 1'b0);
        check_w("t3_aes_key", bus.aes_key, 128'h0);
        check_b("t3_kg_reset", bus.kg_reset, 1'b1);
        check_b("t3_in_ready", bus.in_ready, 1'b0);
        start_session(1'b0);
        check_b("t3_start_ignored", bus.error, 1'b1);
        clear_error();
        check_b("t3_cleared", bus.error, 1'b0);
        check_b("t3_idle", bus.busy, 1'b0);
        check_b("t3_in_ready_back", bus.in_ready, 1'b1);
        kg_block = 1'b0;

        // T4: AES core never finishes; the queued second block must be flushed
        aes_block = 1'b1;
        push(128'ha0a0a0a0_a0a0a0a0_a0a0a0a0_a0a0a0a0, 1'b0, 128'h0, 1'b0);
        push(128'hb1b1b1b1_b1b1b1b1_b1b1b1b1_b1b1b1b1, 1'b1, 128'h0, 1'b0);
        start_session(1'b0);
        wait_run();
        n = 0;
        while (!bus.error && n < int'(AES_TMO) + 50) begin
            tick();
            n++;
        end
        check_w("t4_tmo_cycles", 128'(n), 128'(AES_TMO));
        check_w("t4_err_code", 128'(bus.err_code), 128'(2'b10));
        check_b("t4_aes_reset", bus.aes_reset, 1'b1);
        check_w("t4_aes_din", bus.aes_din, 128'h0);
        check_b("t4_key_ready", bus.key_ready, 1'b0);
        clear_error();
        aes_block = 1'b0;
        start_session(1'b0);
        repeat (20) tick();
        check_b("t4_flushed_busy", bus.busy, 1'b1);
        check_b("t4_flushed_no_run", bus.aes_reset, 1'b1);
        check_w("t4_err_cleared", 128'(bus.err_code), 128'(2'b00));
        push(128'hc2c2c2c2_c2c2c2c2_c2c2c2c2_c2c2c2c2, 1'b1,
             fake_aes(128'hc2c2c2c2_c2c2c2c2_c2c2c2c2_c2c2c2c2, K2), 1'b1);
        wait_idle(kg_low);
        check_w("t4_blk_count", 128'(bus.blk_count), 128'(1));
        check_w("t4_queue_left", 128'(exp_q.size()), 128'(0));

        // T6: asynchronous reset in the middle of RUN
        push(128'hd3d3d3d3_d3d3d3d3_d3d3d3d3_d3d3d3d3, 1'b1, 128'h0, 1'b0);
        start_session(1'b0);
        wait_run();
        #2;
        reset = 1'b1;
        #1;
        check_b("t6_key_ready", bus.key_ready, 1'b0);
        check_w("t6_aes_key", bus.aes_key, 128'h0);
        check_b("t6_kg_reset", bus.kg_reset, 1'b1);
        check_b("t6_aes_reset", bus.aes_reset, 1'b1);
        check_w("t6_aes_din", bus.aes_din, 128'h0);
        check_b("t6_busy", bus.busy, 1'b0);
        check_b("t6_out_valid", bus.out_valid, 1'b0);
        check_w("t6_blk_count", 128'(bus.blk_count), 128'(0));
        check_b("t6_in_ready", bus.in_ready, 1'b0);
        repeat (2) tick();
        reset = 1'b0;
        repeat (10) tick();
        check_b("t6_no_output", bus.out_valid, 1'b0);
        check_b("t6_idle", bus.busy, 1'b0);
        check_w("t6_queue_left", 128'(exp_q.size()), 128'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
